// File: rtl/fir_core_if.sv
// Stream bundle for fir_core: sample input stream (ss_*) and result output stream (sm_*).
// The slave modport is the core's view; master is the producer/consumer side.
interface fir_core_if #(
    parameter int pDATA_WIDTH = 32
);
    logic                   ss_tvalid;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;
    logic                   ss_tready;
    logic                   sm_tvalid;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tlast;
    logic                   sm_tready;

    modport slave (
        input  ss_tvalid, ss_tdata, ss_tlast, sm_tready,
        output ss_tready, sm_tvalid, sm_tdata, sm_tlast
    );

    modport master (
        output ss_tvalid, ss_tdata, ss_tlast, sm_tready,
        input  ss_tready, sm_tvalid, sm_tdata, sm_tlast
    );
endinterface

// File: rtl/fir_core.sv
// Sequential 11-tap FIR: one multiply-accumulate per cycle over a circular
// sample history held in an external data RAM; coefficients come from the config block.
module fir_core #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11,
    parameter int RAM_ADDR    = 4
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ap_start,
    input  logic [31:0]            data_length,
    output logic                   ap_idle,
    output logic                   ap_done,
    output logic [RAM_ADDR-1:0]    fir_raddr,
    input  logic [pDATA_WIDTH-1:0] fir_rdata,
    fir_core_if.slave              axis,
    output logic [3:0]             data_WE,
    output logic                   data_EN,
    output logic [pDATA_WIDTH-1:0] data_Di,
    output logic [pADDR_WIDTH-1:0] data_A,
    input  logic [pDATA_WIDTH-1:0] data_Do
);

    localparam logic [RAM_ADDR-1:0] TAPS     = RAM_ADDR'(Tape_Num);
    localparam logic [RAM_ADDR-1:0] LAST_TAP = RAM_ADDR'(Tape_Num - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT_IN,
        ST_CALC,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t                 state_q;
    logic [31:0]            len_q;
    logic [31:0]            out_cnt_q;
    logic [RAM_ADDR-1:0]    wr_ptr_q;
    logic [RAM_ADDR-1:0]    tap_q;
    logic [pDATA_WIDTH-1:0] acc_q;
    logic [pDATA_WIDTH-1:0] sm_tdata_q;

    logic [pDATA_WIDTH-1:0] prod;
    logic [pDATA_WIDTH-1:0] acc_d;
    logic [RAM_ADDR-1:0]    rd_idx;
    logic                   last_out;
    logic                   unused_tlast;

    function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [RAM_ADDR-1:0] idx);
        return pADDR_WIDTH'({idx, 2'b00});
    endfunction

    assign unused_tlast = axis.ss_tlast;

    always_comb begin
        // Low word of a signed product equals the low word of the unsigned product.
        prod     = fir_rdata * data_Do;
        acc_d    = acc_q + prod;
        rd_idx   = (wr_ptr_q >= tap_q) ? (wr_ptr_q - tap_q) : (wr_ptr_q + TAPS - tap_q);
        last_out = (out_cnt_q + 32'd1) == len_q;

        data_WE   = '0;
        data_EN   = 1'b0;
        data_Di   = '0;
        data_A    = '0;
        fir_raddr = '0;
        case (state_q)
            ST_INIT: begin
                data_WE = '1;
                data_EN = 1'b1;
                data_A  = word_addr(tap_q);
            end
            ST_WAIT_IN: begin
                data_EN = 1'b1;
                data_A  = word_addr(wr_ptr_q);
                if (axis.ss_tvalid) begin
                    data_WE = '1;
                    data_Di = axis.ss_tdata;
                end
            end
            ST_CALC: begin
                data_EN = 1'b1;
                if (tap_q <= LAST_TAP) begin
                    fir_raddr = tap_q;
                    data_A    = word_addr(rd_idx);
                end
            end
            default: ;
        endcase

        ap_idle        = (state_q == ST_IDLE) || (state_q == ST_DONE);
        ap_done        = (state_q == ST_DONE);
        axis.ss_tready = (state_q == ST_WAIT_IN);
        axis.sm_tvalid = (state_q == ST_OUT);
        axis.sm_tlast  = (state_q == ST_OUT) && last_out;
        axis.sm_tdata  = sm_tdata_q;
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            out_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            tap_q      <= '0;
            acc_q      <= '0;
            sm_tdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (ap_start) begin
                        state_q   <= ST_INIT;
                        len_q     <= data_length;
                        out_cnt_q <= '0;
                        wr_ptr_q  <= '0;
                        tap_q     <= '0;
                    end
                end
                ST_INIT: begin
                    if (tap_q == LAST_TAP) begin
                        tap_q   <= '0;
                        state_q <= (len_q == '0) ? ST_DONE : ST_WAIT_IN;
                    end else begin
                        tap_q <= tap_q + RAM_ADDR'(1);
                    end
                end
                ST_WAIT_IN: begin
                    if (axis.ss_tvalid) begin
                        state_q <= ST_CALC;
                        tap_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                ST_CALC: begin
                    // RAM data trails the address by one cycle, so the MAC lags tap_q by one.
                    tap_q <= tap_q + RAM_ADDR'(1);
                    if (tap_q != '0) begin
                        acc_q <= acc_d;
                    end
                    if (tap_q == TAPS) begin
                        sm_tdata_q <= acc_d;
                        state_q    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (axis.sm_tready) begin
                        out_cnt_q <= out_cnt_q + 32'd1;
                        wr_ptr_q  <= (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + RAM_ADDR'(1);
                        state_q   <= last_out ? ST_DONE : ST_WAIT_IN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_core.sv
// Directed bench for fir_core with behavioural tap and data RAMs and
// hand-computed expected results.
module tb_fir_core;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic [31:0] data_length = '0;
    logic        ap_idle, ap_done;
    logic [3:0]  fir_raddr;
    logic [31:0] fir_rdata = '0;
    logic [3:0]  data_WE;
    logic        data_EN;
    logic [31:0] data_Di;
    logic [11:0] data_A;
    logic [31:0] data_Do = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 axis_clk = ~axis_clk;
    always @(posedge axis_clk) cyc <= cyc + 1;

    fir_core_if #(.pDATA_WIDTH(32)) axis ();

    fir_core #(
        .pADDR_WIDTH(12),
        .pDATA_WIDTH(32),
        .Tape_Num(11),
        .RAM_ADDR(4)
    ) dut (
        .axis_clk(axis_clk),
        .axis_rst_n(axis_rst_n),
        .ap_start(ap_start),
        .data_length(data_length),
        .ap_idle(ap_idle),
        .ap_done(ap_done),
        .fir_raddr(fir_raddr),
        .fir_rdata(fir_rdata),
        .axis(axis),
        .data_WE(data_WE),
        .data_EN(data_EN),
        .data_Di(data_Di),
        .data_A(data_A),
        .data_Do(data_Do)
    );

    // Coefficient store (config block) and data RAM, both one-cycle read latency.
    logic [31:0] h   [16];
    logic [31:0] mem [16];

    always @(posedge axis_clk) fir_rdata <= h[fir_raddr];

    always @(posedge axis_clk) begin
        if (data_EN) begin
            data_Do <= mem[data_A[5:2]];
            for (int b = 0; b < 4; b++)
                if (data_WE[b]) mem[data_A[5:2]][8*b +: 8] <= data_Di[8*b +: 8];
        end
    end

    logic [31:0] xs    [32];
    logic [31:0] ys    [32];
    logic        lasts [32];
    int          hs_cyc [32];
    int          vcyc   [32];
    int          n_sent, n_res, start_cyc, done_cyc, stall_cnt, stall_bad;
    bit          timed_out;

    // Starts a run, feeds xs[0..n_in-1], collects results until n_out results and ap_done.
    task automatic run(input int n_in, input int n_out, input logic [31:0] len,
                       input int stall_idx, input int poke);
        bit          vseen;
        logic [31:0] held;
        n_sent = 0; n_res = 0; done_cyc = -1; stall_cnt = 0; stall_bad = 0;
        timed_out = 1'b1; vseen = 1'b0; held = '0;
        @(posedge axis_clk); #1;
        ap_start = 1'b1; data_length = len; start_cyc = cyc;
        @(posedge axis_clk); #1;
        data_length = 32'hDEAD_BEEF;
        for (int k = 0; k < 600; k++) begin
            ap_start        = (poke > 0) && (cyc == start_cyc + poke);
            axis.ss_tvalid  = (n_sent < n_in);
            axis.ss_tdata   = (n_sent < n_in) ? xs[n_sent] : '0;
            axis.sm_tready  = !((n_res == stall_idx) && (stall_cnt < 5));
            @(negedge axis_clk);
            if (ap_done && done_cyc < 0) done_cyc = cyc;
            if (axis.ss_tvalid && axis.ss_tready) begin
                hs_cyc[n_sent] = cyc;
                n_sent++;
            end
            if (axis.sm_tvalid) begin
                if (!vseen) begin
                    vcyc[n_res] = cyc; vseen = 1'b1; held = axis.sm_tdata;
                end
                if (!axis.sm_tready) begin
                    stall_cnt++;
                    if (axis.sm_tdata !== held || axis.ss_tready !== 1'b0) stall_bad++;
                end else begin
                    ys[n_res] = axis.sm_tdata;
                    lasts[n_res] = axis.sm_tlast;
                    n_res++;
                    vseen = 1'b0;
                end
            end
            if (n_res >= n_out && done_cyc >= 0) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge axis_clk); #1;
        end
        ap_start = 1'b0; axis.ss_tvalid = 1'b0; axis.sm_tready = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'hA5A5_0000 + i;
            h[i] = '0;
        end
        axis.ss_tvalid = 1'b0; axis.ss_tdata = '0; axis.ss_tlast = 1'b0; axis.sm_tready = 1'b1;
        axis_rst_n = 1'b0;
        #23;
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL rst_ap_idle: got %b expected 1", ap_idle); end
        checks++; if (ap_done !== 1'b0) begin errors++; $display("FAIL rst_ap_done: got %b expected 0", ap_done); end
        checks++; if (axis.ss_tready !== 1'b0) begin errors++; $display("FAIL rst_ss_tready: got %b expected 0", axis.ss_tready); end
        checks++; if (axis.sm_tvalid !== 1'b0) begin errors++; $display("FAIL rst_sm_tvalid: got %b expected 0", axis.sm_tvalid); end
        checks++; if (axis.sm_tdata !== 32'h0) begin errors++; $display("FAIL rst_sm_tdata: got %h expected 0", axis.sm_tdata); end
        checks++; if (data_WE !== 4'h0 || data_EN !== 1'b0) begin errors++; $display("FAIL rst_ram_ctl: got WE=%h EN=%b expected WE=0 EN=0", data_WE, data_EN); end
        @(negedge axis_clk); axis_rst_n = 1'b1;
        @(negedge axis_clk);
        checks++; if (ap_idle !== 1'b1 || data_EN !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got idle=%b EN=%b expected idle=1 EN=0", ap_idle, data_EN); end
    endtask

    task automatic test_impulse();
        for (int i = 0; i < 11; i++) h[i] = i + 1;
        for (int i = 0; i < 11; i++) xs[i] = (i == 0) ? 32'd1 : 32'd0;
        run(11, 11, 32'd11, -1, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL impulse_timeout: got %0d results expected 11", n_res); end
        for (int i = 0; i < 11; i++) begin
            checks++; if (ys[i] !== 32'(i + 1)) begin errors++; $display("FAIL impulse_y[%0d]: got %h expected %h", i, ys[i], 32'(i + 1)); end
            checks++; if (lasts[i] !== (i == 10)) begin errors++; $display("FAIL impulse_tlast[%0d]: got %b expected %b", i, lasts[i], (i == 10)); end
        end
        @(negedge axis_clk);
        checks++; if (ap_done !== 1'b1 || ap_idle !== 1'b1) begin errors++; $display("FAIL impulse_done: got done=%b idle=%b expected 1 1", ap_done, ap_idle); end
    endtask

    task automatic test_latency_backpressure();
        logic [31:0] exp_y [5];
        exp_y = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd15};
        for (int i = 0; i < 11; i++) h[i] = 32'd1;
        for (int i = 0; i < 5; i++) xs[i] = i + 1;
        run(5, 5, 32'd5, 2, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL latency_timeout: got %0d results expected 5", n_res); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (ys[i] !== exp_y[i]) begin errors++; $display("FAIL latency_y[%0d]: got %0d expected %0d", i, ys[i], exp_y[i]); end
        end
        checks++; if (vcyc[0] - hs_cyc[0] !== 13) begin errors++; $display("FAIL first_valid_latency: got %0d expected 13", vcyc[0] - hs_cyc[0]); end
        checks++; if (stall_cnt !== 5 || stall_bad !== 0) begin errors++; $display("FAIL backpressure_hold: got stall=%0d bad=%0d expected 5 0", stall_cnt, stall_bad); end
        checks++; if (lasts[4] !== 1'b1 || lasts[3] !== 1'b0) begin errors++; $display("FAIL latency_tlast: got %b%b expected 10", lasts[4], lasts[3]); end
    endtask

    task automatic test_arith_wrap();
        for (int i = 0; i < 11; i++) h[i] = '0;
        h[0] = 32'hFFFF_FFFF;
        xs[0] = 32'h7FFF_FFFF;
        run(1, 1, 32'd1, -1, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL arith_timeout: got %0d results expected 1", n_res); end
        checks++; if (ys[0] !== 32'h8000_0001) begin errors++; $display("FAIL arith_wrap: got %h expected 80000001", ys[0]); end
    endtask

    task automatic test_history_wrap();
        for (int i = 0; i < 11; i++) h[i] = 32'd1;
        for (int i = 0; i < 15; i++) xs[i] = 32'd1;
        // The mid-run ap_start pulse and the scrambled data_length must both be ignored.
        run(15, 15, 32'd15, -1, 20);
        checks++; if (timed_out) begin errors++; $display("FAIL history_timeout: got %0d results expected 15", n_res); end
        for (int i = 0; i < 15; i++) begin
            checks++; if (ys[i] !== 32'((i < 11) ? i + 1 : 11)) begin errors++; $display("FAIL history_y[%0d]: got %0d expected %0d", i, ys[i], (i < 11) ? i + 1 : 11); end
        end
        checks++; if (lasts[14] !== 1'b1 || lasts[10] !== 1'b0) begin errors++; $display("FAIL history_tlast: got %b%b expected 10", lasts[14], lasts[10]); end
    endtask

    task automatic test_zero_length();
        logic [31:0] exp_y [3];
        exp_y = '{32'd2, 32'd5, 32'd9};
        xs[0] = 32'd99; xs[1] = 32'd98;
        run(2, 0, 32'd0, -1, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL zero_timeout: got done_cyc=%0d expected a done", done_cyc); end
        checks++; if (n_sent !== 0 || n_res !== 0) begin errors++; $display("FAIL zero_handshakes: got ss=%0d sm=%0d expected 0 0", n_sent, n_res); end
        checks++; if (done_cyc - start_cyc !== 12) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 12", done_cyc - start_cyc); end
        for (int i = 0; i < 11; i++) h[i] = 32'd1;
        xs[0] = 32'd2; xs[1] = 32'd3; xs[2] = 32'd4;
        run(3, 3, 32'd3, -1, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL restart_timeout: got %0d results expected 3", n_res); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (ys[i] !== exp_y[i]) begin errors++; $display("FAIL restart_y[%0d]: got %0d expected %0d", i, ys[i], exp_y[i]); end
        end
    endtask

    task automatic test_reset_mid_calc();
        bit got_hs;
        got_hs = 1'b0;
        for (int i = 0; i < 11; i++) h[i] = 32'd1;
        @(posedge axis_clk); #1;
        ap_start = 1'b1; data_length = 32'd3;
        @(posedge axis_clk); #1;
        ap_start = 1'b0; axis.ss_tvalid = 1'b1; axis.ss_tdata = 32'd7;
        for (int k = 0; k < 40 && !got_hs; k++) begin
            @(negedge axis_clk);
            if (axis.ss_tready) got_hs = 1'b1;
        end
        checks++; if (!got_hs) begin errors++; $display("FAIL midcalc_handshake: got none expected one"); end
        @(posedge axis_clk); #1;
        axis.ss_tvalid = 1'b0;
        repeat (4) @(posedge axis_clk);
        #2 axis_rst_n = 1'b0;
        #1;
        checks++; if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin errors++; $display("FAIL midrst_status: got idle=%b done=%b expected 1 0", ap_idle, ap_done); end
        checks++; if (fir_raddr !== 4'd0 || data_A !== 12'd0) begin errors++; $display("FAIL midrst_addr: got raddr=%0d A=%h expected 0 0", fir_raddr, data_A); end
        checks++; if (data_EN !== 1'b0 || data_WE !== 4'h0 || data_Di !== 32'h0) begin errors++; $display("FAIL midrst_ram: got EN=%b WE=%h Di=%h expected 0", data_EN, data_WE, data_Di); end
        checks++; if (axis.ss_tready !== 1'b0 || axis.sm_tvalid !== 1'b0 || axis.sm_tlast !== 1'b0 || axis.sm_tdata !== 32'h0) begin
            errors++; $display("FAIL midrst_stream: got tready=%b tvalid=%b tlast=%b tdata=%h expected 0", axis.ss_tready, axis.sm_tvalid, axis.sm_tlast, axis.sm_tdata);
        end
        @(negedge axis_clk); axis_rst_n = 1'b1;
        for (int i = 0; i < 11; i++) h[i] = i + 1;
        xs[0] = 32'd5; xs[1] = 32'd6;
        run(2, 2, 32'd2, -1, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL postrst_timeout: got %0d results expected 2", n_res); end
        checks++; if (ys[0] !== 32'd5) begin errors++; $display("FAIL postrst_y[0]: got %0d expected 5", ys[0]); end
        checks++; if (ys[1] !== 32'd16) begin errors++; $display("FAIL postrst_y[1]: got %0d expected 16", ys[1]); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_latency_backpressure();
        test_arith_wrap();
        test_history_wrap();
        test_zero_length();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
